decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
- Parametrised, registered successor of the decode stage: takes one instruction per cycle from fetch and produces a registered ID/EX bundle.
- Adds valid/ready handshakes on both sides, NUM_FWD prioritised forwarding sources, a load-use scoreboard with configurable load latency, and flush handling.
- Sits between fetch and execute. The regfile is external: rs1/rs2 out, rd1/rd2 in, same cycle.

Parameters:
- XLEN, 32, datapath width.
- NUM_FWD, 3, number of forwarding sources; index 0 = youngest = highest priority.
- LOAD_LAT, 1, cycles after a load enters EX during which its result is not forwardable (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_vld  in  1  fetch bundle valid
- in_rdy  out  1  decode accepts the bundle
- in_inst  in  32  instruction
- in_pc  in  XLEN  instruction PC
- rf_rs1, rf_rs2  out  5 each  regfile read addresses; inst[19:15] and inst[24:20]
- rf_rd1, rf_rd2  in  XLEN each  regfile read data
- fwd_we  in  NUM_FWD  per-source write enable
- fwd_dst  in  5*NUM_FWD  per-source destination register
- fwd_dat  in  XLEN*NUM_FWD  per-source data
- flush  in  1  branch flush from execute
- out_vld  out  1  ID/EX bundle valid
- out_rdy  in  1  execute accepts the bundle
- out_inst  out  32  registered instruction; BUBBLE when invalid
- out_pc  out  XLEN  registered PC
- out_dat_a  out  XLEN  operand A
- out_dat_b  out  XLEN  operand B
- out_rd2  out  XLEN  store data
- perf_cnt  out  32  interlock-stall count

Behaviour:
- Reset values: out_vld=0, out_inst=BUBBLE (0x00000013), out_pc/out_dat_a/out_dat_b/out_rd2=0, scoreboard empty, perf_cnt=0.
- Latency: 1 cycle from input handshake to out_vld.
- Output hold: the output register holds its contents while out_vld & ~out_rdy.
- in_rdy = (~out_vld | out_rdy) & ~interlock, or 1 when flush is high.
- Immediate decode:
  - I/S/B/U/J formats as per RV32I.
  - Selection by opcode: LUI/AUIPC→U, STORE→S, JAL→J, BRANCH→B, otherwise I.
  - Sign-extend to XLEN.
- Read enables:
  - rs1 used by OP_IMM, OP_RR, LOAD, STORE, JALR, BRANCH.
  - rs2 used by OP_RR, STORE, BRANCH.
- Forwarding, per operand: the lowest index i with fwd_we[i] & fwd_dst[i]!=0 & fwd_dst[i]==rs & read-enable selects fwd_dat[i]. Otherwise the operand takes rf_rd. x0 always reads 0.
- Operand B:
  - JALR: in_pc + i_imm, computed internally and wrapping mod 2^XLEN.
  - OP_RR/BRANCH: forwarded rs2.
  - Otherwise: imm.
- Scoreboard:
  - Fields: sb_dst[4:0], sb_cnt[2:0].
  - Set: on an output handshake of a LOAD with rd!=0, sb_dst=rd and sb_cnt=LOAD_LAT.
  - Countdown: sb_cnt decrements by 1 each cycle while nonzero and out_rdy=1. It holds while execute stalls.
  - A new load handshake in the same cycle as a decrement overwrites the entry.
- Interlock = in_vld & sb_cnt!=0 & ((rs1 read-enable & rs1==sb_dst) | (rs2 read-enable & rs2==sb_dst)).
  - While interlock is set, the output loads BUBBLE with out_vld=0 whenever the register is free.
- Flush:
  - Next cycle: out_vld=0 and out_inst=BUBBLE.
  - The input accepted in the flush cycle is discarded.
  - The scoreboard is unaffected, because loads already in EX are older than the flushing branch.
- Flush in the same cycle as interlock: flush wins and in_rdy=1.
- Reset asserted mid-stall: all state returns to reset values next cycle.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- With the macro: perf_cnt increments by 1 on each cycle with interlock=1 and flush=0. It saturates at 0xFFFFFFFF and clears on rst.
- Without the macro: perf_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package utils_top holds:
  - opcode constants OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_RR;
  - BUBBLE;
  - a typedef for the scoreboard entry.
- One sub-module, decode_fwd_mux: a parametrised (XLEN, NUM_FWD) priority forwarding mux with inputs rs, re, rf_dat and the fwd_* buses. It is instantiated twice, once per operand.

Test Plan:
- Reset: hold rst 2 cycles → out_vld=0, out_inst=0x00000013, perf_cnt=0; in_rdy=1 after release.
- Forward priority: ADD x3,x1,x2 with fwd0 (x1=0xAAAA) and fwd2 (x1=0x5555) both hitting, rf_rd1=0x1 → out_dat_a=0xAAAA one cycle later.
- Load-use, LOAD_LAT=2: LW x5 handshaken, then ADD x6,x5,x0 → in_rdy=0 for 2 out_rdy cycles; then accepted. perf_cnt=2 when the feature is enabled.
- Back-pressure: out_rdy=0 for 3 cycles with a valid bundle → outputs stable, in_rdy=0, sb_cnt frozen.
- Flush: flush=1 with in_vld=1 and out_vld=1 → next cycle out_vld=0, out_inst=BUBBLE, and the input instruction never appears.
- JALR: in_pc=0xFFFFFFF0, imm=0x20 → out_dat_b=0x00000010 (wrap-around).

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions: RV32I opcodes, BUBBLE, scoreboard entry.
// Imported by decode_stage_pipe and decode_fwd_mux.
package utils_top;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RR     = 7'b0110011;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  typedef struct packed {
    logic [4:0] dst;
    logic [2:0] cnt;
  } sb_t;

endpackage

// File: rtl/decode_stage_pipe_fwd_mux.sv
// Priority forwarding mux: lowest-index matching source wins, x0 reads 0.
// Ports: rs/re select, rf_dat fallback, fwd_we/fwd_dst/fwd_dat buses, dat out.
module decode_fwd_mux
  import utils_top::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              rs,
  input  logic                    re,
  input  logic [XLEN-1:0]         rf_dat,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [5*NUM_FWD-1:0]    fwd_dst,
  input  logic [XLEN*NUM_FWD-1:0] fwd_dat,
  output logic [XLEN-1:0]         dat
);

  logic hit;

  always_comb begin
    dat = rf_dat;
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && re && fwd_we[i] &&
          fwd_dst[5*i +: 5] == rs) begin
        hit = 1'b1;
        dat = fwd_dat[XLEN*i +: XLEN];
      end
    end
    if (rs == 5'd0) dat = '0;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: immediates, forwarding, load-use interlock, flush.
// Ports: fetch in_* / execute out_* handshakes, rf_*, fwd_*, flush, perf_cnt.
// Option: DECODE_PERF_CNT_EN enables the saturating interlock-stall counter.
module decode_stage_pipe
  import utils_top::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  output logic [4:0]              rf_rs1,
  output logic [4:0]              rf_rs2,
  input  logic [XLEN-1:0]         rf_rd1,
  input  logic [XLEN-1:0]         rf_rd2,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [5*NUM_FWD-1:0]    fwd_dst,
  input  logic [XLEN*NUM_FWD-1:0] fwd_dat,
  input  logic                    flush,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_dat_a,
  output logic [XLEN-1:0]         out_dat_b,
  output logic [XLEN-1:0]         out_rd2,
  output logic [31:0]             perf_cnt
);

  logic [6:0] opc;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_load, is_store, is_imm, is_rr;
  logic re1, re2;

  assign opc      = in_inst[6:0];
  assign is_lui   = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_jal   = opc == OP_JAL;
  assign is_jalr  = opc == OP_JALR;
  assign is_br    = opc == OP_BRANCH;
  assign is_load  = opc == OP_LOAD;
  assign is_store = opc == OP_STORE;
  assign is_imm   = opc == OP_IMM;
  assign is_rr    = opc == OP_RR;

  assign re1 = is_imm | is_rr | is_load |
               is_store | is_jalr | is_br;
  assign re2 = is_rr | is_store | is_br;

  assign rf_rs1 = in_inst[19:15];
  assign rf_rs2 = in_inst[24:20];

  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm32;

  assign i_imm = {{20{in_inst[31]}}, in_inst[31:20]};
  assign s_imm = {{20{in_inst[31]}}, in_inst[31:25],
                  in_inst[11:7]};
  assign b_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign u_imm = {in_inst[31:12], 12'h000};
  assign j_imm = {{11{in_inst[31]}}, in_inst[31],
                  in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};

  always_comb begin
    imm32 = i_imm;
    unique case (1'b1)
      is_lui, is_auipc: imm32 = u_imm;
      is_store:         imm32 = s_imm;
      is_jal:           imm32 = j_imm;
      is_br:            imm32 = b_imm;
      default:          imm32 = i_imm;
    endcase
  end

  logic [XLEN-1:0] imm, i_ext, jalr_tgt;
  logic [XLEN-1:0] opa, opr2, opb;

  assign imm      = XLEN'($signed(imm32));
  assign i_ext    = XLEN'($signed(i_imm));
  assign jalr_tgt = in_pc + i_ext;

  decode_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_a (
    .rs(rf_rs1), .re(re1), .rf_dat(rf_rd1),
    .fwd_we(fwd_we), .fwd_dst(fwd_dst),
    .fwd_dat(fwd_dat), .dat(opa)
  );

  decode_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_b (
    .rs(rf_rs2), .re(re2), .rf_dat(rf_rd2),
    .fwd_we(fwd_we), .fwd_dst(fwd_dst),
    .fwd_dat(fwd_dat), .dat(opr2)
  );

  always_comb begin
    opb = imm;
    unique case (1'b1)
      is_jalr:       opb = jalr_tgt;
      is_rr | is_br: opb = opr2;
      default:       opb = imm;
    endcase
  end

  sb_t  sb;
  logic interlock, free, load_hs;

  assign interlock = in_vld && sb.cnt != 3'd0 &&
                     ((re1 && rf_rs1 == sb.dst) ||
                      (re2 && rf_rs2 == sb.dst));
  assign free   = !out_vld || out_rdy;
  assign in_rdy = flush || (free && !interlock);

  // A load becomes unforwardable the moment execute takes it.
  assign load_hs = out_vld && out_rdy &&
                   out_inst[6:0] == OP_LOAD &&
                   out_inst[11:7] != 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else if (load_hs) begin
      sb.dst <= out_inst[11:7];
      sb.cnt <= 3'(LOAD_LAT);
    end else if (sb.cnt != 3'd0 && out_rdy) begin
      sb.cnt <= sb.cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_inst  <= BUBBLE;
      out_pc    <= '0;
      out_dat_a <= '0;
      out_dat_b <= '0;
      out_rd2   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      out_inst <= BUBBLE;
    end else if (free) begin
      if (in_vld && !interlock) begin
        out_vld   <= 1'b1;
        out_inst  <= in_inst;
        out_pc    <= in_pc;
        out_dat_a <= opa;
        out_dat_b <= opb;
        out_rd2   <= opr2;
      end else begin
        out_vld  <= 1'b0;
        out_inst <= BUBBLE;
      end
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (interlock && !flush &&
                 perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule
